benes_cfg_ctrl: RTL and testbench

BENES_CFG_CTRL -- requirements
Module: benes_cfg_ctrl

---
 rtl/benes_pkg.sv | 27 ++
 rtl/benes_vld_pipe.sv | 37 +++
 rtl/benes_cfg_ctrl.sv | 140 ++++++++++++++
 tb/tb_benes_cfg_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/benes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : benes_pkg
// Description : Shared sizes, types and FSM states for the Benes config ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package benes_pkg;

   localparam int N_PORTS      = 16;
   localparam int PORT_W       = 4;
   localparam int N_STAGES     = 7;
   localparam int SW_PER_STAGE = 8;
   localparam int STAGE_W      = 3;

   localparam logic [N_STAGES-1:0] c_full_mask = '1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   typedef logic [N_STAGES-1:0][SW_PER_STAGE-1:0] sw_cfg_t;
   typedef logic [N_PORTS-1:0][PORT_W-1:0]        port_vec_t;

endpackage
`default_nettype wire

// File: rtl/benes_vld_pipe.sv
`default_nettype none
// ============================================================================
// Module      : benes_vld_pipe
// Description : Valid delay line tracking in-flight beats, with any-busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module benes_vld_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_vld,
   output logic out_vld,
   output logic busy
);

   logic [DEPTH-1:0] r_pipe;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_pipe <= '0;
            else        r_pipe <= in_vld;
         end
      end else begin : g_shift
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_pipe <= '0;
            else        r_pipe <= {r_pipe[DEPTH-2:0], in_vld};
         end
      end
   endgenerate

   assign out_vld = r_pipe[DEPTH-1];
   assign busy    = |r_pipe;

endmodule
`default_nettype wire

// File: rtl/benes_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : benes_cfg_ctrl
// Description : Shadow/active configuration control for a pipelined Benes net.
// Revision    : 1.0 - initial release
// ============================================================================
module benes_cfg_ctrl
   import benes_pkg::*;
#(
   parameter int NET_LAT = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   cfg_valid,
   output logic                                   cfg_ready,
   input  logic [STAGE_W-1:0]                     cfg_stage,
   input  logic [SW_PER_STAGE-1:0]                cfg_bits,
   input  logic                                   cfg_last,
   output logic                                   cfg_err,
   output logic [7:0]                             cfg_epoch,
   output logic [N_STAGES-1:0][SW_PER_STAGE-1:0]  switch_set,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [N_PORTS-1:0][PORT_W-1:0]         in_data,
   output logic [N_PORTS-1:0][PORT_W-1:0]         i_port,
   input  logic [N_PORTS-1:0][PORT_W-1:0]         o_port,
   output logic                                   out_valid,
   output logic [N_PORTS-1:0][PORT_W-1:0]         out_data
);

   state_t              r_state, w_state_nxt;
   sw_cfg_t             r_shadow, r_switch_set;
   logic [N_STAGES-1:0] r_mask, w_mask_nxt, w_mask_wr, w_stage_onehot;
   logic [7:0]          r_epoch;
   logic                r_cfg_err, w_cfg_err_nxt;
   port_vec_t           r_i_port;
   logic                w_run, w_cfg_acc, w_in_acc, w_stage_ok;
   logic                w_shadow_we, w_commit, w_pipe_busy, w_out_valid;

   // Handshakes are forced low while reset is held, not just after the next edge.
   assign w_run     = (r_state == ST_RUN) && rst_n;
   assign w_cfg_acc = cfg_valid && w_run;
   assign w_in_acc  = in_valid && w_run;

   assign w_stage_ok     = (cfg_stage < STAGE_W'(N_STAGES));
   assign w_stage_onehot = {{(N_STAGES-1){1'b0}}, 1'b1} << cfg_stage;
   assign w_mask_wr      = r_mask | w_stage_onehot;

   benes_vld_pipe #(
      .DEPTH (NET_LAT + 1)
   ) u_vld_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (w_in_acc),
      .out_vld (w_out_valid),
      .busy    (w_pipe_busy)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_mask_nxt    = r_mask;
      w_cfg_err_nxt = 1'b0;
      w_shadow_we   = 1'b0;
      w_commit      = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_cfg_acc) begin
               if (!w_stage_ok) begin
                  w_cfg_err_nxt = 1'b1;
               end else begin
                  w_shadow_we = 1'b1;
                  if (!cfg_last) begin
                     w_mask_nxt = w_mask_wr;
                  end else if (w_mask_wr == c_full_mask) begin
                     w_mask_nxt  = w_mask_wr;
                     w_state_nxt = ST_DRAIN;
                  end else begin
                     // Incomplete configuration: reject and restart collection.
                     w_cfg_err_nxt = 1'b1;
                     w_mask_nxt    = '0;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (!w_pipe_busy) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_commit    = 1'b1;
            w_mask_nxt  = '0;
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_mask    <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mask    <= w_mask_nxt;
         r_cfg_err <= w_cfg_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow     <= '0;
         r_switch_set <= '0;
         r_epoch      <= 8'd0;
      end else begin
         if (w_shadow_we) r_shadow[cfg_stage] <= cfg_bits;
         if (w_commit) begin
            r_switch_set <= r_shadow;
            r_epoch      <= r_epoch + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_i_port <= '0;
      else if (w_in_acc) r_i_port <= in_data;
   end

   assign cfg_ready  = w_run;
   assign in_ready   = w_run;
   assign cfg_err    = r_cfg_err;
   assign cfg_epoch  = r_epoch;
   assign switch_set = r_switch_set;
   assign i_port     = r_i_port;
   assign out_valid  = w_out_valid;
   assign out_data   = w_out_valid ? o_port : '0;

endmodule
`default_nettype wire

// File: tb/tb_benes_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_benes_cfg_ctrl
// Description : Directed scoreboard bench for benes_cfg_ctrl with a toy network.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_benes_cfg_ctrl;
   import benes_pkg::*;

   localparam int NET_LAT = 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cfg_valid, cfg_ready, cfg_last, cfg_err;
   logic [STAGE_W-1:0]  cfg_stage;
   logic [7:0]          cfg_bits, cfg_epoch;
   sw_cfg_t             switch_set;
   logic                in_valid, in_ready, out_valid;
   port_vec_t           in_data, i_port, out_data;
   port_vec_t           o_port = '0;

   typedef struct {
      port_vec_t data;
      int        cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0, n_err = 0, cyc = 0, err_cnt = 0, n_acc = 0, n_out = 0;
   sw_cfg_t     exp_sw = '0;
   logic [7:0]  exp_epoch = 8'd0;

   benes_cfg_ctrl #(.NET_LAT(NET_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_stage  (cfg_stage),
      .cfg_bits   (cfg_bits),
      .cfg_last   (cfg_last),
      .cfg_err    (cfg_err),
      .cfg_epoch  (cfg_epoch),
      .switch_set (switch_set),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .i_port     (i_port),
      .o_port     (o_port),
      .out_valid  (out_valid),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   // Stand-in network: port permutation and value scramble keyed by the configuration.
   function automatic port_vec_t net_model(input port_vec_t d, input sw_cfg_t sw);
      port_vec_t r;
      for (int j = 0; j < N_PORTS; j++)
         r[j] = d[j ^ int'(sw[0][3:0])] ^ sw[j % N_STAGES][PORT_W-1:0];
      return r;
   endfunction

   always @(posedge clk) o_port <= net_model(i_port, switch_set);

   function automatic port_vec_t pat(input int beat);
      port_vec_t r;
      for (int i = 0; i < N_PORTS; i++) r[i] = PORT_W'(15 - i) ^ PORT_W'(beat);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      if (in_valid && in_ready) begin
         e.data = net_model(in_data, exp_sw);
         e.cyc  = cyc;
         sb.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cfg_err) err_cnt++;
      if (out_valid) begin
         n_out++;
         chk("sb_nonempty_on_out_valid", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_latency", 64'(cyc - e.cyc), 64'(NET_LAT + 1));
         end
      end
   endtask

   task automatic wait_cfg_ready();
      int k = 0;
      while (!cfg_ready && k < 50) begin
         tick();
         k++;
      end
      if (!cfg_ready) chk("cfg_ready_timeout", cfg_ready, 1);
   endtask

   task automatic write_cfg(input int stg, input logic [7:0] bits, input logic last);
      cfg_valid = 1'b1;
      cfg_stage = STAGE_W'(stg);
      cfg_bits  = bits;
      cfg_last  = last;
      wait_cfg_ready();
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic commit_cfg(input sw_cfg_t v);
      for (int s = 0; s < N_STAGES; s++) write_cfg(s, v[s], s == N_STAGES - 1);
      wait_cfg_ready();
      exp_sw    = v;
      exp_epoch = exp_epoch + 8'd1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sw_cfg_t v;
      int      e0, k, beat;

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_stage = '0; cfg_bits = '0; cfg_last = 1'b0;
      in_valid = 1'b1; in_data = pat(0);

      // Reset state, with upstream valid held to show nothing is accepted.
      @(negedge clk);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_switch_set", switch_set, 0);
      chk("rst_epoch", cfg_epoch, 0);
      chk("rst_i_port", i_port, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cfg_err", cfg_err, 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      chk("run_cfg_ready", cfg_ready, 1);
      chk("run_in_ready", in_ready, 1);

      // Full configuration commit.
      v  = {8'h55, 8'h55, 8'h55, 8'h69, 8'h69, 8'h3C, 8'h0E};
      e0 = err_cnt;
      for (int s = 0; s < N_STAGES; s++) write_cfg(s, v[s], s == N_STAGES - 1);
      chk("drain_cfg_ready", cfg_ready, 0);
      chk("drain_in_ready", in_ready, 0);
      chk("pre_commit_switch_set", switch_set, exp_sw);
      wait_cfg_ready();
      exp_sw = v; exp_epoch = 8'd1;
      chk("commit_switch_set", switch_set, exp_sw);
      chk("commit_epoch", cfg_epoch, exp_epoch);
      chk("commit_no_err", err_cnt - e0, 0);

      // Incomplete configuration: stages 0..5 only.
      e0 = err_cnt;
      for (int s = 0; s < N_STAGES - 1; s++) write_cfg(s, 8'($urandom), s == N_STAGES - 2);
      tick();
      chk("partial_err_pulses", err_cnt - e0, 1);
      chk("partial_stays_run", cfg_ready, 1);
      chk("partial_switch_set", switch_set, exp_sw);
      chk("partial_epoch", cfg_epoch, exp_epoch);
      e0 = err_cnt;
      write_cfg(6, 8'hFF, 1'b1);
      tick();
      chk("mask_cleared_err", err_cnt - e0, 1);
      chk("mask_cleared_run", cfg_ready, 1);

      // Out-of-range stage.
      v  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      for (int s = 0; s < N_STAGES - 1; s++) write_cfg(s, v[s], 1'b0);
      e0 = err_cnt;
      write_cfg(7, 8'hA5, 1'b0);
      tick();
      chk("bad_stage_err", err_cnt - e0, 1);
      chk("bad_stage_epoch", cfg_epoch, exp_epoch);
      write_cfg(6, v[6], 1'b1);
      wait_cfg_ready();
      exp_sw = v; exp_epoch = exp_epoch + 8'd1;
      chk("bad_stage_commit", switch_set, exp_sw);
      chk("bad_stage_commit_epoch", cfg_epoch, exp_epoch);

      // Streaming with a commit whose last write coincides with a data beat.
      beat = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin in_data = pat(beat); beat++; tick(); end
      v = {8'hC3, 8'h5A, 8'h96, 8'h0F, 8'hF0, 8'h24, 8'h09};
      for (int s = 0; s < N_STAGES; s++) begin
         cfg_valid = 1'b1; cfg_stage = STAGE_W'(s); cfg_bits = v[s];
         cfg_last  = (s == N_STAGES - 1);
         in_data   = pat(beat); beat++;
         tick();
      end
      cfg_valid = 1'b0; cfg_last = 1'b0;
      in_data   = pat(beat); beat++;
      chk("stream_drain_in_ready", in_ready, 0);
      k = 0;
      while (!in_ready && k < 20) begin tick(); k++; end
      chk("stream_drain_ticks", k, NET_LAT + 3);
      chk("stream_sb_empty_at_commit", 64'(sb.size()), 0);
      exp_sw = v; exp_epoch = exp_epoch + 8'd1;
      chk("stream_switch_set", switch_set, exp_sw);
      chk("stream_epoch", cfg_epoch, exp_epoch);
      for (int i = 0; i < 4; i++) begin tick(); in_data = pat(beat); beat++; end
      in_valid = 1'b0;
      for (int i = 0; i < NET_LAT + 3; i++) tick();
      chk("stream_acc_vs_out", n_out, n_acc);
      chk("stream_sb_empty", 64'(sb.size()), 0);

      // Epoch wrap over 256 commits.
      e0 = int'(exp_epoch);
      for (int n = 0; n < 256; n++) begin
         for (int s = 0; s < N_STAGES; s++) v[s] = 8'($urandom);
         commit_cfg(v);
         if (exp_epoch == 8'd0) chk("epoch_wrap_zero", cfg_epoch, 0);
      end
      chk("epoch_after_256", cfg_epoch, 64'(e0));
      chk("switch_set_after_256", switch_set, exp_sw);

      // Reset asserted while draining.
      v = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45};
      for (int s = 0; s < N_STAGES; s++) begin
         in_valid = (s == N_STAGES - 1);
         in_data  = pat(beat);
         write_cfg(s, v[s], s == N_STAGES - 1);
      end
      in_valid = 1'b0;
      chk("pre_reset_in_drain", cfg_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_cfg_ready", cfg_ready, 0);
      chk("async_rst_in_ready", in_ready, 0);
      chk("async_rst_switch_set", switch_set, 0);
      chk("async_rst_epoch", cfg_epoch, 0);
      chk("async_rst_i_port", i_port, 0);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_cfg_err", cfg_err, 0);
      chk("async_rst_out_data", out_data, 0);
      sb.delete();
      exp_sw = '0; exp_epoch = 8'd0;
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_switch_set", switch_set, exp_sw);
      chk("post_rst_epoch", cfg_epoch, exp_epoch);
      chk("post_rst_cfg_ready", cfg_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
